// File: rtl/sobel_pkg.sv
// Shared types and default frame geometry for the Sobel pixel-stream front end.
package sobel_pkg;

    localparam int SOBEL_PIXEL_WIDTH  = 8;
    localparam int SOBEL_IMAGE_WIDTH  = 64;
    localparam int SOBEL_IMAGE_HEIGHT = 48;
    localparam int SOBEL_ADDR_WIDTH   = 12;
    localparam int SOBEL_ROW_WIDTH    = $clog2(SOBEL_IMAGE_HEIGHT);
    localparam int SOBEL_COL_WIDTH    = $clog2(SOBEL_IMAGE_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_t;

    // Pixel plus the window tags that travel with it through the output buffer.
    typedef struct packed {
        logic [SOBEL_PIXEL_WIDTH-1:0] pix;
        logic                         first;
        logic                         last;
        logic [SOBEL_ROW_WIDTH-1:0]   row;
        logic [SOBEL_COL_WIDTH-1:0]   col;
    } px_tag_t;

endpackage

// File: rtl/sobel_px_skid_fifo.sv
// Two-entry output buffer for tagged window pixels; push and pop may coincide,
// including on a full buffer, where the popped slot is refilled at the same edge.
module sobel_px_skid_fifo
    import sobel_pkg::*;
#(
    parameter type T = px_tag_t
) (
    input  logic       clk_i,
    input  logic       nreset_i,
    input  logic       push_i,
    input  T           push_data_i,
    input  logic       pop_i,
    output T           pop_data_o,
    output logic [1:0] count_o
);

    T           mem_q [2];
    T           mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0);
        do_push  = push_i && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/sobel_window_feeder.sv
// Walks every 3x3 window of a row-major frame in RAM (row inner, column outer)
// and streams its 9 pixels, row-major within the window, to the Sobel consumer.
module sobel_window_feeder
    import sobel_pkg::*;
#(
    parameter int  PIXEL_WIDTH  = SOBEL_PIXEL_WIDTH,
    parameter int  IMAGE_WIDTH  = SOBEL_IMAGE_WIDTH,
    parameter int  IMAGE_HEIGHT = SOBEL_IMAGE_HEIGHT,
    parameter int  ADDR_WIDTH   = SOBEL_ADDR_WIDTH,
    localparam int ROW_W        = $clog2(IMAGE_HEIGHT),
    localparam int COL_W        = $clog2(IMAGE_WIDTH)
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   mem_rd_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic [PIXEL_WIDTH-1:0] mem_rdata_i,
    output logic [PIXEL_WIDTH-1:0] px_o,
    output logic                   px_valid_o,
    input  logic                   px_ready_i,
    output logic                   px_first_o,
    output logic                   px_last_o,
    output logic [ROW_W-1:0]       win_row_o,
    output logic [COL_W-1:0]       win_col_o,
    output logic                   frame_done_o,
    output feeder_state_t          dbg_state_o
);

    // Handshake: a pixel moves when px_valid_o && px_ready_i at a rising edge; once
    // raised, px_valid_o and its payload stay put until that transfer happens.

    typedef struct packed {
        logic [PIXEL_WIDTH-1:0] pix;
        logic                   first;
        logic                   last;
        logic [ROW_W-1:0]       row;
        logic [COL_W-1:0]       col;
    } tag_t;

    localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(IMAGE_HEIGHT - 3);
    localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMAGE_WIDTH - 3);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(IMAGE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] WRAP_STEP = ADDR_WIDTH'(IMAGE_WIDTH - 2);

    if (IMAGE_WIDTH < 3 || IMAGE_HEIGHT < 3) begin : g_bad_geometry
        $error("sobel_window_feeder: IMAGE_WIDTH and IMAGE_HEIGHT must both be >= 3");
    end
    if ((1 << ADDR_WIDTH) < IMAGE_WIDTH * IMAGE_HEIGHT) begin : g_bad_addr
        $error("sobel_window_feeder: ADDR_WIDTH too small for the frame");
    end

    feeder_state_t           state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [1:0]              krow_q, krow_d;
    logic [1:0]              kcol_q, kcol_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic                    inflight_q, inflight_d;
    tag_t                    flight_q, flight_d;

    logic [1:0] fifo_count;
    tag_t       head;
    tag_t       push_data;
    logic       pop;
    logic       issue;
    logic       last_rd;
    logic [2:0] credit_used;

    always_comb begin
        pop         = (fifo_count != 2'd0) && px_ready_i;
        // A slot freed by this cycle's transfer can already be promised to a new read.
        credit_used = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
        issue       = (state_q == ST_FETCH) && (credit_used < 3'd2);
        last_rd     = (row_q == LAST_ROW) && (col_q == LAST_COL)
                      && (krow_q == 2'd2) && (kcol_q == 2'd2);
        push_data     = flight_q;
        push_data.pix = mem_rdata_i;

        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        krow_d     = krow_q;
        kcol_d     = kcol_q;
        addr_d     = addr_q;
        base_d     = base_q;
        inflight_d = issue;
        flight_d   = flight_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    row_d   = '0;
                    col_d   = '0;
                    krow_d  = 2'd0;
                    kcol_d  = 2'd0;
                    addr_d  = '0;
                    base_d  = '0;
                end
            end
            ST_FETCH: begin
                if (issue && last_rd) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue) begin
            flight_d.pix   = '0;
            flight_d.first = (krow_q == 2'd0) && (kcol_q == 2'd0);
            flight_d.last  = (krow_q == 2'd2) && (kcol_q == 2'd2);
            flight_d.row   = row_q;
            flight_d.col   = col_q;
            if (kcol_q != 2'd2) begin
                kcol_d = kcol_q + 2'd1;
                addr_d = addr_q + ADDR_WIDTH'(1);
            end else if (krow_q != 2'd2) begin
                kcol_d = 2'd0;
                krow_d = krow_q + 2'd1;
                addr_d = addr_q + WRAP_STEP;
            end else begin
                kcol_d = 2'd0;
                krow_d = 2'd0;
                // Next window is one row down, or the top of the next column.
                if (row_q != LAST_ROW) begin
                    row_d  = row_q + ROW_W'(1);
                    base_d = base_q + ROW_STEP;
                    addr_d = base_q + ROW_STEP;
                end else begin
                    row_d  = '0;
                    col_d  = col_q + COL_W'(1);
                    base_d = ADDR_WIDTH'(col_q) + ADDR_WIDTH'(1);
                    addr_d = ADDR_WIDTH'(col_q) + ADDR_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            krow_q     <= 2'd0;
            kcol_q     <= 2'd0;
            addr_q     <= '0;
            base_q     <= '0;
            inflight_q <= 1'b0;
            flight_q   <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            krow_q     <= krow_d;
            kcol_q     <= kcol_d;
            addr_q     <= addr_d;
            base_q     <= base_d;
            inflight_q <= inflight_d;
            flight_q   <= flight_d;
        end
    end

    sobel_px_skid_fifo #(
        .T (tag_t)
    ) u_fifo (
        .clk_i       (clk_i),
        .nreset_i    (nreset_i),
        .push_i      (inflight_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (head),
        .count_o     (fifo_count)
    );

    assign busy_o       = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign mem_rd_o     = issue;
    assign mem_addr_o   = addr_q;
    assign px_valid_o   = (fifo_count != 2'd0);
    assign px_o         = px_valid_o ? head.pix : '0;
    assign px_first_o   = px_valid_o && head.first;
    assign px_last_o    = px_valid_o && head.last;
    assign win_row_o    = px_valid_o ? head.row : '0;
    assign win_col_o    = px_valid_o ? head.col : '0;
    assign frame_done_o = (state_q == ST_DONE);
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Bench for sobel_window_feeder: a 4x4 and a 5x3 instance, RAM models, and a
// window-order reference model feeding a scoreboard queue.
module tb_sobel_window_feeder;
  import sobel_pkg::*;

  localparam time CLK_PERIOD = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nreset;
  initial forever #(CLK_PERIOD / 2) clk = ~clk;

  // ---------------- DUT A: 4x4 ----------------
  logic          start_a, busy_a, rd_a, valid_a, first_a, last_a, done_a;
  logic [7:0]    addr_a, rdata_a, px_a;
  logic [1:0]    row_a, col_a;
  feeder_state_t state_a;

  // ---------------- DUT B: 5x3 ----------------
  logic          start_b, busy_b, rd_b, valid_b, first_b, last_b, done_b;
  logic [7:0]    addr_b, rdata_b, px_b;
  logic [1:0]    row_b;
  logic [2:0]    col_b;
  feeder_state_t state_b;

  logic px_ready;

  sobel_window_feeder #(
    .PIXEL_WIDTH(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .ADDR_WIDTH(8)
  ) u_dut_a (
    .clk_i(clk), .nreset_i(nreset), .start_i(start_a), .busy_o(busy_a),
    .mem_rd_o(rd_a), .mem_addr_o(addr_a), .mem_rdata_i(rdata_a),
    .px_o(px_a), .px_valid_o(valid_a), .px_ready_i(px_ready),
    .px_first_o(first_a), .px_last_o(last_a), .win_row_o(row_a), .win_col_o(col_a),
    .frame_done_o(done_a), .dbg_state_o(state_a)
  );

  sobel_window_feeder #(
    .PIXEL_WIDTH(8), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(3), .ADDR_WIDTH(8)
  ) u_dut_b (
    .clk_i(clk), .nreset_i(nreset), .start_i(start_b), .busy_o(busy_b),
    .mem_rd_o(rd_b), .mem_addr_o(addr_b), .mem_rdata_i(rdata_b),
    .px_o(px_b), .px_valid_o(valid_b), .px_ready_i(px_ready),
    .px_first_o(first_b), .px_last_o(last_b), .win_row_o(row_b), .win_col_o(col_b),
    .frame_done_o(done_b), .dbg_state_o(state_b)
  );

  // ---------------- RAM models (data one cycle after the strobe) ----------------
  logic [7:0] ram_a [16];
  logic [7:0] ram_b [16];
  always @(posedge clk) begin
    if (rd_a) rdata_a <= ram_a[addr_a[3:0]];
    if (rd_b) rdata_b <= ram_b[addr_b[3:0]];
  end

  // ---------------- observation mux ----------------
  bit            sel;
  int            frame_w, frame_h;
  logic          obs_busy, obs_rd, obs_valid, obs_first, obs_last, obs_done;
  logic [7:0]    obs_addr, obs_px;
  logic [6:0]    obs_row, obs_col;
  feeder_state_t obs_state;
  logic [23:0]   obs_word;

  always_comb begin
    if (sel) begin
      obs_busy = busy_b; obs_rd = rd_b; obs_valid = valid_b; obs_first = first_b;
      obs_last = last_b; obs_done = done_b; obs_addr = addr_b; obs_px = px_b;
      obs_row = 7'(row_b); obs_col = 7'(col_b); obs_state = state_b;
    end else begin
      obs_busy = busy_a; obs_rd = rd_a; obs_valid = valid_a; obs_first = first_a;
      obs_last = last_a; obs_done = done_a; obs_addr = addr_a; obs_px = px_a;
      obs_row = 7'(row_a); obs_col = 7'(col_a); obs_state = state_a;
    end
    obs_word = {obs_px, obs_first, obs_last, obs_row, obs_col};
  end

  // ---------------- ready driver ----------------
  int  ready_mode;
  time hold_end;
  int  phase;
  initial begin
    px_ready = 1'b0;
    phase = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: px_ready = 1'b1;
        1: begin
          phase = (phase == 2) ? 0 : phase + 1;
          px_ready = (phase == 0);
        end
        2: px_ready = 1'($urandom_range(0, 1));
        default: px_ready = ($time < hold_end) ? 1'b0 : 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else start_a = v;
  endtask

  task automatic fill_ram(input bit ramp);
    for (int a = 0; a < 16; a++) begin
      logic [7:0] v;
      v = ramp ? 8'(a) : 8'($urandom_range(0, 255));
      if (sel) ram_b[a] = v;
      else ram_a[a] = v;
    end
  endtask

  // Reference: windows with row inner / column outer, pixels row-major inside.
  task automatic build_expected();
    exp_q.delete();
    for (int c = 0; c <= frame_w - 3; c++)
      for (int r = 0; r <= frame_h - 3; r++)
        for (int k = 0; k < 9; k++) begin
          int a;
          logic [7:0] pix;
          a = (r + k / 3) * frame_w + c + k % 3;
          pix = sel ? ram_b[a] : ram_a[a];
          exp_q.push_back({pix, (k == 0), (k == 8), 7'(r), 7'(c)});
        end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ctl"}, {obs_busy, obs_rd, obs_valid, obs_done, obs_first, obs_last}, 0);
    check_eq({tag, "_data"}, {obs_addr, obs_word}, 0);
    check_eq({tag, "_state"}, 64'(obs_state), 64'(ST_IDLE));
  endtask

  task automatic select_dut(input bit s);
    sel = s;
    frame_w = s ? 5 : 4;
    frame_h = s ? 3 : 4;
  endtask

  task automatic run_frame(input int rmode, input bit hold_chk, input bit mid_start,
                           input int reset_at, input bit timing_chk);
    int cyc = 0, rd_cnt = 0, xfer_cnt = 0, done_cnt = 0, n_exp;
    int first_rd = -1, first_valid = -1, last_xfer = -1, done_cyc = -1;
    bit finished = 0, rst_hit = 0, prev_stall = 0, xfer;
    logic [23:0] prev_word = '0;
    build_expected();
    n_exp = exp_q.size();
    @(posedge clk); #1;
    ready_mode = rmode;
    hold_end = $time + 22 * CLK_PERIOD;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    while (!finished) begin
      @(negedge clk);
      xfer = obs_valid && px_ready;
      if (obs_rd) begin
        rd_cnt++;
        if (first_rd < 0) begin
          first_rd = cyc;
          check_eq("first_addr", obs_addr, 0);
        end
        check_eq("credit", ((rd_cnt - xfer_cnt - int'(xfer)) <= 2), 1);
      end
      if (prev_stall) begin
        check_eq("stall_valid", obs_valid, 1);
        check_eq("stall_hold", obs_word, prev_word);
      end
      if (obs_valid && first_valid < 0) first_valid = cyc;
      if (xfer) begin
        if (exp_q.size() == 0) check_eq("xfer_count", xfer_cnt + 1, n_exp);
        else check_eq($sformatf("px%0d", xfer_cnt), obs_word, exp_q.pop_front());
        xfer_cnt++;
        last_xfer = cyc;
      end
      if (obs_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == 5) check_eq("busy_mid", obs_busy, 1);
      if (hold_chk && cyc == 15) begin
        check_eq("hold_reads", rd_cnt, 2);
        check_eq("hold_px", obs_word, exp_q[0]);
      end
      if (mid_start && cyc == 10) set_start(1'b1);
      if (mid_start && cyc == 11) set_start(1'b0);
      prev_stall = obs_valid && !px_ready;
      prev_word = obs_word;
      if (reset_at > 0 && xfer_cnt == reset_at) begin
        #1 nreset = 1'b0;
        #1 check_outputs_zero("rst_async");
        @(posedge clk); #1;
        check_outputs_zero("rst_edge");
        check_eq("rst_no_done", done_cnt, 0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        exp_q.delete();
        rst_hit = 1;
        finished = 1;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) finished = 1;
      if (cyc >= 3000) begin
        check_eq("timeout_done", done_cnt, 1);
        finished = 1;
      end
      cyc++;
    end
    if (!rst_hit) begin
      check_eq("done_count", done_cnt, 1);
      check_eq("xfers", xfer_cnt, n_exp);
      check_eq("exp_empty", exp_q.size(), 0);
      check_eq("done_after_last", done_cyc, last_xfer + 1);
      check_eq("busy_after", obs_busy, 0);
      if (timing_chk) begin
        check_eq("first_rd_cyc", first_rd, 0);
        check_eq("first_valid_cyc", first_valid, 2);
        check_eq("done_cyc", done_cyc, n_exp + 2);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    nreset = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    ready_mode = 0;
    hold_end = 0;
    select_dut(1'b0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_a");
    select_dut(1'b1);
    #1 check_outputs_zero("reset_b");
    @(negedge clk);
    nreset = 1'b1;

    select_dut(1'b0);
    fill_ram(1'b1);
    run_frame(0, 1'b0, 1'b0, 0, 1'b1);
    run_frame(1, 1'b0, 1'b0, 0, 1'b0);
    run_frame(3, 1'b1, 1'b0, 0, 1'b0);
    fill_ram(1'b0);
    run_frame(2, 1'b0, 1'b1, 0, 1'b0);
    fill_ram(1'b0);
    run_frame(2, 1'b0, 1'b0, 17, 1'b0);
    fill_ram(1'b0);
    run_frame(0, 1'b0, 1'b0, 0, 1'b1);

    select_dut(1'b1);
    fill_ram(1'b1);
    run_frame(0, 1'b0, 1'b0, 0, 1'b1);
    fill_ram(1'b0);
    run_frame(2, 1'b0, 1'b1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
